plic_prio: RTL and testbench

Parametrised priority interrupt controller, the successor to the CPU's fixed 3-source PLIC. It accepts `NUM_SRC` external interrupt lines, each with per-source enable, level/edge mode and priority. It also provides a global threshold and a claim/complete handshake with the CPU core. It sits between the accelerator/DMA interrupt sources and the CPU CSR unit, and drives the interrupt-taken/ID pair and a WFI wake signal.

---
 rtl/plic_pkg.sv | 28 ++
 rtl/plic_gateway.sv | 62 ++++++
 rtl/plic_prio.sv | 173 +++++++++++++++++
 tb/tb_plic_prio.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plic_pkg
// Description : Shared constants and types for the plic_prio interrupt
//               controller: config register map, "no interrupt" ID and the
//               priority container type used by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package plic_pkg;

   // Config register map
   localparam logic [7:0] ADDR_ENABLE    = 8'h00;
   localparam logic [7:0] ADDR_EDGE      = 8'h01;
   localparam logic [7:0] ADDR_THRESHOLD = 8'h02;
   localparam logic [7:0] ADDR_PENDING   = 8'h03;
   localparam logic [7:0] ADDR_INSERVICE = 8'h04;
   localparam logic [7:0] ADDR_PRIO_BASE = 8'h10;

   // ID presented when no source is eligible
   localparam int INT_ID_NONE = 0;

   // Widest priority field supported; per-source priorities are zero-extended
   // into this type for comparison.
   localparam int PRIO_BITS_MAX = 8;
   typedef logic [PRIO_BITS_MAX-1:0] prio_t;

endpackage
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
// Module      : plic_gateway
// Description : Per-source interrupt gateway. Holds the previous irq sample
//               for edge detection, the pending bit (level or edge capture)
//               and the in-service bit driven by claim / complete.
// Revision    : 1.0 - initial release
// ============================================================================
module plic_gateway (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   input  logic edge_mode_i,
   input  logic claim_i,
   input  logic complete_i,
   output logic pending_o,
   output logic in_service_o
);

   logic irq_prev_q, irq_prev_d;
   logic pending_q, pending_d;
   logic in_service_q, in_service_d;

   // Next-state: claim moves pending into service; a fresh capture wins over
   // the claim-clear so an edge arriving with the claim is not lost.
   always_comb begin
      irq_prev_d   = irq_i;
      pending_d    = pending_q;
      in_service_d = in_service_q;
      if (claim_i) begin
         pending_d    = 1'b0;
         in_service_d = 1'b1;
      end else if (complete_i) begin
         in_service_d = 1'b0;
      end
      if (edge_mode_i) begin
         if (irq_i && !irq_prev_q) begin
            pending_d = 1'b1;
         end
      end else if (irq_i && !in_service_q && !claim_i) begin
         pending_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev_q   <= 1'b0;
         pending_q    <= 1'b0;
         in_service_q <= 1'b0;
      end else begin
         irq_prev_q   <= irq_prev_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   assign pending_o    = pending_q;
   assign in_service_o = in_service_q;

endmodule
`default_nettype wire

// File: rtl/plic_prio.sv
`default_nettype none
// ============================================================================
// Module      : plic_prio
// Description : Parametrised priority interrupt controller. Config registers,
//               per-source gateways, highest-priority / lowest-ID arbitration
//               and the registered interrupt-taken / ID / wake outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module plic_prio
   import plic_pkg::*;
#(
   parameter int NUM_SRC   = 8,
   parameter int PRIO_BITS = 3,
   parameter int ID_BITS   = $clog2(NUM_SRC + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_i,
   input  logic               cfg_we_i,
   input  logic [7:0]         cfg_addr_i,
   input  logic [31:0]        cfg_wdata_i,
   output logic [31:0]        cfg_rdata_o,
   input  logic               claim_i,
   input  logic               complete_i,
   input  logic [ID_BITS-1:0] complete_id_i,
   output logic               int_taken_o,
   output logic [ID_BITS-1:0] int_id_o,
   output logic               wake_o
);

   logic [NUM_SRC-1:0]   enable_q, enable_d;
   logic [NUM_SRC-1:0]   edge_q, edge_d;
   logic [PRIO_BITS-1:0] threshold_q, threshold_d;
   logic [PRIO_BITS-1:0] prio_q [NUM_SRC];
   logic [PRIO_BITS-1:0] prio_d [NUM_SRC];

   logic                 int_taken_q, int_taken_d;
   logic [ID_BITS-1:0]   int_id_q, int_id_d;
   logic                 wake_q, wake_d;

   logic [NUM_SRC-1:0]   pending;
   logic [NUM_SRC-1:0]   in_service;
   logic [NUM_SRC-1:0]   claim_vec;
   logic [NUM_SRC-1:0]   complete_vec;
   logic [NUM_SRC-1:0]   eligible;
   logic                 claim_accept;
   prio_t                best_prio;
   logic [ID_BITS-1:0]   best_id;
   logic                 unused_wdata;

   // Upper write-data bits are deliberately ignored
   assign unused_wdata = ^cfg_wdata_i;

   // A claim only counts while something is actually presented
   assign claim_accept = claim_i && int_taken_q;

   generate
      for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
         assign claim_vec[k]    = claim_accept && (int_id_q == ID_BITS'(k + 1));
         assign complete_vec[k] = complete_i && (complete_id_i == ID_BITS'(k + 1));

         plic_gateway u_gateway (
            .clk          (clk),
            .rst          (rst),
            .irq_i        (irq_i[k]),
            .edge_mode_i  (edge_q[k]),
            .claim_i      (claim_vec[k]),
            .complete_i   (complete_vec[k]),
            .pending_o    (pending[k]),
            .in_service_o (in_service[k])
         );
      end
   endgenerate

   // Config register writes; out-of-range bits and unmapped addresses dropped
   always_comb begin
      enable_d    = enable_q;
      edge_d      = edge_q;
      threshold_d = threshold_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         prio_d[k] = prio_q[k];
      end
      if (cfg_we_i) begin
         case (cfg_addr_i)
            ADDR_ENABLE:    enable_d    = cfg_wdata_i[NUM_SRC-1:0];
            ADDR_EDGE:      edge_d      = cfg_wdata_i[NUM_SRC-1:0];
            ADDR_THRESHOLD: threshold_d = cfg_wdata_i[PRIO_BITS-1:0];
            default:        ;
         endcase
         for (int k = 0; k < NUM_SRC; k++) begin
            if (cfg_addr_i == ADDR_PRIO_BASE + 8'(k)) begin
               prio_d[k] = cfg_wdata_i[PRIO_BITS-1:0];
            end
         end
      end
   end

   // Combinational config read-back
   always_comb begin
      cfg_rdata_o = '0;
      case (cfg_addr_i)
         ADDR_ENABLE:    cfg_rdata_o = 32'(enable_q);
         ADDR_EDGE:      cfg_rdata_o = 32'(edge_q);
         ADDR_THRESHOLD: cfg_rdata_o = 32'(threshold_q);
         ADDR_PENDING:   cfg_rdata_o = 32'(pending);
         ADDR_INSERVICE: cfg_rdata_o = 32'(in_service);
         default:        ;
      endcase
      for (int k = 0; k < NUM_SRC; k++) begin
         if (cfg_addr_i == ADDR_PRIO_BASE + 8'(k)) begin
            cfg_rdata_o = 32'(prio_q[k]);
         end
      end
   end

   // Arbitration: scan from highest ID down with >= so the lowest ID wins
   // ties; eligible priorities are always >= 1 so a zero start is safe.
   always_comb begin
      eligible  = '0;
      best_prio = '0;
      best_id   = ID_BITS'(INT_ID_NONE);
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         eligible[k] = pending[k] && enable_q[k] && !in_service[k] &&
                       (prio_q[k] > threshold_q);
         if (eligible[k] && (prio_t'(prio_q[k]) >= best_prio)) begin
            best_prio = prio_t'(prio_q[k]);
            best_id   = ID_BITS'(k + 1);
         end
      end
   end

   // Output register; blanked on an accepted claim so no stale ID survives
   always_comb begin
      int_taken_d = |eligible;
      int_id_d    = best_id;
      wake_d      = |(pending & enable_q);
      if (claim_accept) begin
         int_taken_d = 1'b0;
         int_id_d    = ID_BITS'(INT_ID_NONE);
      end
   end

   // Config and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_q    <= '0;
         edge_q      <= '0;
         threshold_q <= '0;
         for (int k = 0; k < NUM_SRC; k++) begin
            prio_q[k] <= '0;
         end
         int_taken_q <= 1'b0;
         int_id_q    <= ID_BITS'(INT_ID_NONE);
         wake_q      <= 1'b0;
      end else begin
         enable_q    <= enable_d;
         edge_q      <= edge_d;
         threshold_q <= threshold_d;
         for (int k = 0; k < NUM_SRC; k++) begin
            prio_q[k] <= prio_d[k];
         end
         int_taken_q <= int_taken_d;
         int_id_q    <= int_id_d;
         wake_q      <= wake_d;
      end
   end

   assign int_taken_o = int_taken_q;
   assign int_id_o    = int_id_q;
   assign wake_o      = wake_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_prio.sv
`default_nettype none
// ============================================================================
// Module      : tb_plic_prio
// Description : Self-checking bench for plic_prio. A behavioural model of the
//               controller is stepped once per clock and every output is
//               compared after each edge; directed scenarios add literal
//               expectations, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_prio;

   localparam int NUM_SRC   = 8;
   localparam int PRIO_BITS = 3;
   localparam int ID_BITS   = 4;
   localparam int PMASK     = (1 << PRIO_BITS) - 1;

   logic               clk;
   logic               rst;
   logic [NUM_SRC-1:0] irq;
   logic               cfg_we;
   logic [7:0]         cfg_addr;
   logic [31:0]        cfg_wdata;
   logic [31:0]        cfg_rdata;
   logic               claim;
   logic               complete;
   logic [ID_BITS-1:0] complete_id;
   logic               int_taken;
   logic [ID_BITS-1:0] int_id;
   logic               wake;

   int checks   = 0;
   int failures = 0;

   // Model state
   bit m_pend  [NUM_SRC];
   bit m_insvc [NUM_SRC];
   bit m_prev  [NUM_SRC];
   bit m_en    [NUM_SRC];
   bit m_edge  [NUM_SRC];
   int m_prio  [NUM_SRC];
   int m_thr;
   bit m_taken;
   int m_id;
   bit m_wake;

   plic_prio #(
      .NUM_SRC   (NUM_SRC),
      .PRIO_BITS (PRIO_BITS),
      .ID_BITS   (ID_BITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_i         (irq),
      .cfg_we_i      (cfg_we),
      .cfg_addr_i    (cfg_addr),
      .cfg_wdata_i   (cfg_wdata),
      .cfg_rdata_o   (cfg_rdata),
      .claim_i       (claim),
      .complete_i    (complete),
      .complete_id_i (complete_id),
      .int_taken_o   (int_taken),
      .int_id_o      (int_id),
      .wake_o        (wake)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_SRC; k++) begin
         m_pend[k] = 0; m_insvc[k] = 0; m_prev[k] = 0;
         m_en[k] = 0; m_edge[k] = 0; m_prio[k] = 0;
      end
      m_thr = 0; m_taken = 0; m_id = 0; m_wake = 0;
   endtask

   function automatic bit m_elig(int k);
      return m_pend[k] && m_en[k] && !m_insvc[k] && (m_prio[k] > m_thr);
   endfunction

   function automatic logic [31:0] model_read(logic [7:0] a);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         case (a)
            8'h00: r[k] = m_en[k];
            8'h01: r[k] = m_edge[k];
            8'h03: r[k] = m_pend[k];
            8'h04: r[k] = m_insvc[k];
            default: ;
         endcase
      end
      if (a == 8'h02) r = 32'(m_thr);
      if (a >= 8'h10 && int'(a) < 16 + NUM_SRC) r = 32'(m_prio[int'(a) - 16]);
      return r;
   endfunction

   // Advance the model by one clock edge using the current inputs
   task automatic model_step();
      int  best, win;
      bit  acc, claimed, completed, setp, any;
      bit  n_taken;
      int  n_id;
      acc  = claim && m_taken;
      best = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (m_elig(k) && m_prio[k] > best) best = m_prio[k];
      win = 0;
      for (int k = 0; k < NUM_SRC; k++)
         if (win == 0 && m_elig(k) && m_prio[k] == best) win = k + 1;
      n_taken = acc ? 1'b0 : (win != 0);
      n_id    = acc ? 0 : win;
      any = 0;
      for (int k = 0; k < NUM_SRC; k++) any |= m_pend[k] & m_en[k];
      for (int k = 0; k < NUM_SRC; k++) begin
         claimed   = acc && (m_id == k + 1);
         completed = complete && (int'(complete_id) == k + 1);
         if (m_edge[k]) setp = irq[k] && !m_prev[k];
         else           setp = irq[k] && !m_insvc[k] && !claimed;
         if (claimed) begin
            m_pend[k] = 0; m_insvc[k] = 1;
         end else if (completed) begin
            m_insvc[k] = 0;
         end
         if (setp) m_pend[k] = 1;
         m_prev[k] = irq[k];
      end
      if (cfg_we) begin
         if (cfg_addr == 8'h00) for (int k = 0; k < NUM_SRC; k++) m_en[k] = cfg_wdata[k];
         if (cfg_addr == 8'h01) for (int k = 0; k < NUM_SRC; k++) m_edge[k] = cfg_wdata[k];
         if (cfg_addr == 8'h02) m_thr = int'(cfg_wdata) & PMASK;
         if (cfg_addr >= 8'h10 && int'(cfg_addr) < 16 + NUM_SRC)
            m_prio[int'(cfg_addr) - 16] = int'(cfg_wdata) & PMASK;
      end
      m_taken = n_taken;
      m_id    = n_id;
      m_wake  = any;
   endtask

   // One clock: step model, then compare all outputs after the edge
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("int_taken", 32'(int_taken), 32'(m_taken));
      chk("int_id", 32'(int_id), 32'(m_id));
      chk("wake", 32'(wake), 32'(m_wake));
      chk("cfg_rdata", cfg_rdata, model_read(cfg_addr));
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic do_claim();
      claim = 1'b1;
      cycle();
      claim = 1'b0;
   endtask

   task automatic do_complete(input int id);
      complete = 1'b1; complete_id = ID_BITS'(id);
      cycle();
      complete = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      chk(name, cfg_rdata, exp);
      chk({name, "_model"}, cfg_rdata, model_read(a));
   endtask

   // Asynchronous reset between edges; outputs must drop immediately
   task automatic async_reset(input string name);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk({name, "_taken"}, 32'(int_taken), 0);
      chk({name, "_id"}, 32'(int_id), 0);
      chk({name, "_wake"}, 32'(wake), 0);
      cfg_addr = 8'h04;
      #1;
      chk({name, "_insvc"}, cfg_rdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      claim = 1'b0; complete = 1'b0; complete_id = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_taken", 32'(int_taken), 0);
      chk("reset_id", 32'(int_id), 0);
      chk("reset_wake", 32'(wake), 0);
      read_chk("reset_enable", 8'h00, 0);

      // Single source, two-cycle latency, claim blanks output
      cfg_write(8'h10, 2);
      cfg_write(8'h00, 1);
      cfg_write(8'h02, 0);
      irq = 8'h01; cycle(); irq = '0; cycle();
      chk("t1_taken", 32'(int_taken), 1);
      chk("t1_id", 32'(int_id), 1);
      do_claim();
      chk("t1_blank", 32'(int_taken), 0);
      read_chk("t1_insvc", 8'h04, 1);
      do_complete(1);

      // Equal priorities: lowest ID first
      cfg_write(8'h12, 5);
      cfg_write(8'h15, 5);
      cfg_write(8'h00, 32'h25);
      irq = 8'h24; cycle(); irq = '0; cycle();
      chk("t2_id3", 32'(int_id), 3);
      do_claim();
      chk("t2_blank", 32'(int_id), 0);
      cycle();
      chk("t2_id6", 32'(int_id), 6);
      do_claim();
      do_complete(3);
      do_complete(6);

      // Threshold gating vs wake
      cfg_write(8'h11, 4);
      cfg_write(8'h00, 32'h27);
      cfg_write(8'h02, 4);
      irq = 8'h02; cycle(); irq = '0; cycle();
      chk("t3_taken", 32'(int_taken), 0);
      chk("t3_wake", 32'(wake), 1);
      cfg_write(8'h02, 3);
      cycle();
      chk("t3_id2", 32'(int_id), 2);
      do_claim();
      do_complete(2);
      cfg_write(8'h02, 0);

      // Level source held high across claim/complete
      cfg_write(8'h13, 6);
      cfg_write(8'h00, 32'h08);
      irq = 8'h08; cycle(); cycle();
      chk("t4_id4", 32'(int_id), 4);
      do_claim();
      cycle(); cycle();
      chk("t4_insvc_hidden", 32'(int_taken), 0);
      do_complete(4);
      chk("t4_c0", 32'(int_taken), 0);
      cycle();
      chk("t4_c1", 32'(int_taken), 0);
      cycle();
      chk("t4_c2_id", 32'(int_id), 4);
      do_claim();
      irq = '0;
      do_complete(4);

      // Edge source: second edge during service is latched
      cfg_write(8'h01, 32'h08);
      irq = 8'h08; cycle(); cycle();
      chk("t5_id4", 32'(int_id), 4);
      do_claim();
      irq = '0; cycle();
      irq = 8'h08; cycle();
      cycle();
      read_chk("t5_pending", 8'h03, 32'h08);
      chk("t5_hidden", 32'(int_taken), 0);
      do_complete(4);
      chk("t5_c0", 32'(int_taken), 0);
      cycle();
      chk("t5_c1_id", 32'(int_id), 4);
      do_claim();
      do_complete(4);
      irq = '0;
      cfg_write(8'h01, 0);

      // Ignored claim / complete, then reset mid-service
      cfg_write(8'h00, 32'h05);
      irq = 8'h01; cycle(); irq = '0; cycle();
      do_claim();
      read_chk("t6_insvc", 8'h04, 1);
      do_claim();
      read_chk("t6_idle_claim", 8'h04, 1);
      do_complete(0);
      read_chk("t6_cmp0", 8'h04, 1);
      do_complete(5);
      read_chk("t6_cmp5", 8'h04, 1);
      do_complete(15);
      read_chk("t6_cmp15", 8'h04, 1);
      irq = 8'h04; cycle(); irq = '0; cycle();
      chk("t6_id3", 32'(int_id), 3);
      chk("t6_wake", 32'(wake), 1);
      async_reset("t6_rst");

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         irq      = irq ^ NUM_SRC'($urandom & $urandom & $urandom);
         claim    = ($urandom_range(0, 2) == 0);
         complete = ($urandom_range(0, 2) == 0);
         complete_id = ID_BITS'($urandom_range(0, NUM_SRC + 2));
         cfg_we   = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 5))
            0: cfg_addr = 8'h00;
            1: cfg_addr = 8'h01;
            2: cfg_addr = 8'h02;
            3: cfg_addr = 8'(16 + $urandom_range(0, NUM_SRC + 1));
            4: cfg_addr = 8'(3 + $urandom_range(0, 1));
            default: cfg_addr = 8'($urandom);
         endcase
         cfg_wdata = $urandom;
         cycle();
         if (i % 700 == 699) begin
            cfg_we = 1'b0; claim = 1'b0; complete = 1'b0;
            async_reset("rand_rst");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
